// File: rtl/display_pkg.sv
// display_pkg
// Shared constants and types for the multiplexed 7-segment display driver.
//   - Segment codes are active-low, bit 7..1 = a..g, bit 0 = dp (dp off here).
//   - AN_OFF turns every anode off.
//   - digitIdx_t names the four scanned digit positions.
//   - splitField breaks a 0..127 binary field into tens/units and flags
//     values above 99 so they can be shown as dashes.
package display_pkg;

   localparam logic [7:0] SEG_0    = 8'h03;
   localparam logic [7:0] SEG_1    = 8'h9F;
   localparam logic [7:0] SEG_2    = 8'h25;
   localparam logic [7:0] SEG_3    = 8'h0D;
   localparam logic [7:0] SEG_4    = 8'h99;
   localparam logic [7:0] SEG_5    = 8'h49;
   localparam logic [7:0] SEG_6    = 8'h41;
   localparam logic [7:0] SEG_7    = 8'h1F;
   localparam logic [7:0] SEG_8    = 8'h01;
   localparam logic [7:0] SEG_9    = 8'h09;
   localparam logic [7:0] SEG_DASH = 8'hFD;
   localparam logic [7:0] SEG_OFF  = 8'hFF;

   localparam logic [7:0] AN_OFF   = 8'hFF;

   // Scan order: seconds units first, minutes tens last.
   typedef enum logic [1:0] {
      DIG_SEC_UNITS = 2'd0,
      DIG_SEC_TENS  = 2'd1,
      DIG_MIN_UNITS = 2'd2,
      DIG_MIN_TENS  = 2'd3
   } digitIdx_t;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] units;
      logic       outOfRange;
   } fieldDigits_t;

   // Values above 99 cannot be shown with two digits; the caller shows dashes.
   function automatic fieldDigits_t splitField(input logic [6:0] value);
      fieldDigits_t result;
      result.tens       = 4'(value / 7'd10);
      result.units      = 4'(value % 7'd10);
      result.outOfRange = (value > 7'd99);
      return result;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
// Combinational BCD digit to active-low 7-segment pattern (a..g, no dp).
// Ports:
//   digit_i  4-bit digit 0..9 (other codes give all segments off)
//   dash_i   when high, show a dash regardless of digit_i
//   seg_o    segments a..g, active-low, bit 6 = a
module seg7_decode
   import display_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       dash_i,
   output logic [6:0] seg_o
);

   // Dash wins over the digit value; the decimal point is handled by the caller.
   always_comb begin
      seg_o = SEG_OFF[7:1];
      if (dash_i) begin
         seg_o = SEG_DASH[7:1];
      end else begin
         case (digit_i)
            4'd0:    seg_o = SEG_0[7:1];
            4'd1:    seg_o = SEG_1[7:1];
            4'd2:    seg_o = SEG_2[7:1];
            4'd3:    seg_o = SEG_3[7:1];
            4'd4:    seg_o = SEG_4[7:1];
            4'd5:    seg_o = SEG_5[7:1];
            4'd6:    seg_o = SEG_6[7:1];
            4'd7:    seg_o = SEG_7[7:1];
            4'd8:    seg_o = SEG_8[7:1];
            4'd9:    seg_o = SEG_9[7:1];
            default: seg_o = SEG_OFF[7:1];
         endcase
      end
   end

endmodule

// File: rtl/display_scan.sv
// display_scan
// Time-multiplexed driver for four digits (MM:SS) of an eight-digit,
// active-low 7-segment display, fed by a countdown timer.
// Parameters:
//   REFRESH_DIV  clock cycles each digit stays lit (>= 2)
//   BLINK_DIV    clock cycles per blink half-period (>= 2), blink build only
// Ports:
//   clock     system clock, rising edge
//   reset     synchronous, active-high
//   min_left  remaining minutes, binary 0..127 (>99 shows dashes)
//   sec_left  remaining seconds, binary 0..127 (>99 shows dashes)
//   blank     all digits off while high
//   done      timer finished; blinks the display in the blink build
//   an        anode enables, active-low, one-hot-low while scanning
//   dec_cat   segments a..g on bits 7..1, dp on bit 0, active-low
// Build option:
//   DISPLAY_BLINK_EN  when defined, the anodes blink while done is high.
//                     When undefined, done is ignored and no blink logic exists.
module display_scan
   import display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLINK_DIV   = 50000000
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] min_left,
   input  logic [6:0] sec_left,
   input  logic       blank,
   input  logic       done,
   output logic [7:0] an,
   output logic [7:0] dec_cat
);

   localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

   logic [6:0]       minQ;
   logic [6:0]       secQ;
   logic             blankQ;
   logic [REF_W-1:0] refCntQ;
   logic [REF_W-1:0] refCntD;
   digitIdx_t        digitIdxQ;
   digitIdx_t        digitIdxD;
   logic [7:0]       anQ;
   logic [7:0]       anD;
   logic [7:0]       catQ;
   logic [7:0]       catD;

   fieldDigits_t     minDigits;
   fieldDigits_t     secDigits;
   logic [3:0]       curDigit;
   logic             curDash;
   logic             curDpN;
   logic [7:0]       anScan;
   logic [6:0]       segBits;
   logic             blinkOff;

   // Inputs are captured every cycle, including during reset, so the first
   // digit after reset already shows the live values.
   always_ff @(posedge clock) begin
      minQ   <= min_left;
      secQ   <= sec_left;
      blankQ <= blank;
   end

   // Refresh counter and digit index; the index steps when the counter wraps.
   always_comb begin
      refCntD   = refCntQ + REF_W'(1);
      digitIdxD = digitIdxQ;
      if (refCntQ == REF_LAST) begin
         refCntD   = '0;
         digitIdxD = digitIdx_t'(digitIdxQ + 2'd1);
      end
   end

   assign minDigits = splitField(minQ);
   assign secDigits = splitField(secQ);

   // Select the digit for the current index. The dp acts as the min:sec
   // separator on the minutes-units digit, but is dropped when minutes are
   // out of range so the two dashes read as one marker.
   always_comb begin
      curDigit = 4'd0;
      curDash  = 1'b0;
      curDpN   = 1'b1;
      anScan   = AN_OFF;
      case (digitIdxQ)
         DIG_SEC_UNITS: begin
            curDigit = secDigits.units;
            curDash  = secDigits.outOfRange;
            anScan   = 8'b1111_1110;
         end
         DIG_SEC_TENS: begin
            curDigit = secDigits.tens;
            curDash  = secDigits.outOfRange;
            anScan   = 8'b1111_1101;
         end
         DIG_MIN_UNITS: begin
            curDigit = minDigits.units;
            curDash  = minDigits.outOfRange;
            curDpN   = minDigits.outOfRange;
            anScan   = 8'b1111_1011;
         end
         default: begin
            curDigit = minDigits.tens;
            curDash  = minDigits.outOfRange;
            anScan   = 8'b1111_0111;
         end
      endcase
   end

   seg7_decode u_decode (
      .digit_i (curDigit),
      .dash_i  (curDash),
      .seg_o   (segBits)
   );

`ifdef DISPLAY_BLINK_EN
   localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic               doneQ;
   logic [BLINK_W-1:0] blinkCntQ;
   logic [BLINK_W-1:0] blinkCntD;
   logic               blinkPhaseOffQ;
   logic               blinkPhaseOffD;

   // done is captured alongside the other inputs.
   always_ff @(posedge clock) begin
      doneQ <= done;
   end

   // Blink counter only runs while done is held; dropping done clears it
   // and returns to the on phase immediately.
   always_comb begin
      blinkCntD      = '0;
      blinkPhaseOffD = 1'b0;
      if (doneQ) begin
         if (blinkCntQ == BLINK_LAST) begin
            blinkCntD      = '0;
            blinkPhaseOffD = ~blinkPhaseOffQ;
         end else begin
            blinkCntD      = blinkCntQ + BLINK_W'(1);
            blinkPhaseOffD = blinkPhaseOffQ;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         blinkCntQ      <= '0;
         blinkPhaseOffQ <= 1'b0;
      end else begin
         blinkCntQ      <= blinkCntD;
         blinkPhaseOffQ <= blinkPhaseOffD;
      end
   end

   // Gating with doneQ lets scanning return one cycle sooner after done drops.
   assign blinkOff = doneQ & blinkPhaseOffQ;
`else
   logic unusedCfg;

   // done and BLINK_DIV stay on the interface but have no function here.
   assign unusedCfg = done & (BLINK_DIV > 32'd1);
   assign blinkOff  = 1'b0;
`endif

   // Output priority: blank, then blink-off phase, then normal scan.
   always_comb begin
      anD  = anScan;
      catD = {segBits, curDpN};
      if (blankQ) begin
         anD  = AN_OFF;
         catD = SEG_OFF;
      end else if (blinkOff) begin
         anD = AN_OFF;
      end
   end

   // Scan state and the output registers; an and dec_cat update together.
   always_ff @(posedge clock) begin
      if (reset) begin
         refCntQ   <= '0;
         digitIdxQ <= DIG_SEC_UNITS;
         anQ       <= AN_OFF;
         catQ      <= SEG_OFF;
      end else begin
         refCntQ   <= refCntD;
         digitIdxQ <= digitIdxD;
         anQ       <= anD;
         catQ      <= catD;
      end
   end

   assign an      = anQ;
   assign dec_cat = catQ;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan
// Scoreboard bench for display_scan. A driver applies one input set per
// cycle and pushes the display the reference model predicts for the next
// rising edge; a monitor pops one prediction per cycle and compares it.
// The model works from scan position arithmetic: the digit shown after the
// j-th edge since reset is ((j-1)/REFRESH_DIV) mod 4, using the inputs
// captured on the edge before.
module tb_display_scan;

   localparam int unsigned REFRESH_DIV = 4;
   localparam int unsigned BLINK_DIV   = 8;
`ifdef DISPLAY_BLINK_EN
   localparam bit BLINK_BUILD = 1'b1;
`else
   localparam bit BLINK_BUILD = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] min_left = 7'd0;
   logic [6:0] sec_left = 7'd0;
   logic       blank = 1'b0;
   logic       done = 1'b0;
   logic [7:0] an;
   logic [7:0] dec_cat;

   display_scan #(
      .REFRESH_DIV (REFRESH_DIV),
      .BLINK_DIV   (BLINK_DIV)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .min_left (min_left),
      .sec_left (sec_left),
      .blank    (blank),
      .done     (done),
      .an       (an),
      .dec_cat  (dec_cat)
   );

   always #5 clock = ~clock;

   logic [15:0] expQ [$];
   int          checks = 0;
   int          failures = 0;
   int          cycleNum = 0;

   logic [7:0]  segTab [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

   int          edgesSinceReset = -1;
   logic [6:0]  prevMin = 7'd0;
   logic [6:0]  prevSec = 7'd0;
   logic        prevBlank = 1'b0;
   logic        prevDone = 1'b0;
   int          doneRun = 0;

   // Reference display for a scan position and captured inputs: {an, dec_cat}.
   function automatic logic [15:0] modelOutput(input int idx, input logic [6:0] mins,
                                                input logic [6:0] secs, input logic blk,
                                                input logic blinkOff);
      int         field;
      int         digitVal;
      logic [7:0] seg;
      logic [7:0] anExp;
      if (blk) return 16'hFFFF;
      field = (idx < 2) ? int'(secs) : int'(mins);
      if (field > 99) begin
         seg = 8'hFD;
      end else begin
         digitVal = (idx % 2 == 1) ? field / 10 : field % 10;
         seg = segTab[digitVal];
         if (idx == 2) seg = seg & 8'hFE;
      end
      anExp = 8'hFF;
      anExp[idx] = 1'b0;
      if (blinkOff) anExp = 8'hFF;
      return {anExp, seg};
   endfunction

   // Drive one cycle of inputs and predict the display after the next edge.
   task automatic applyStimulus(input logic rst, input logic [6:0] m, input logic [6:0] s,
                                input logic b, input logic d);
      logic blinkOff;
      int   nextRun;
      @(negedge clock);
      reset    = rst;
      min_left = m;
      sec_left = s;
      blank    = b;
      done     = d;
      blinkOff = BLINK_BUILD && prevDone &&
                 ((((doneRun - 1) / int'(BLINK_DIV)) % 2) == 1);
      if (rst) begin
         expQ.push_back(16'hFFFF);
         edgesSinceReset = 0;
         nextRun = d ? 1 : 0;
      end else begin
         nextRun = d ? doneRun + 1 : 0;
         if (edgesSinceReset >= 0) begin
            edgesSinceReset++;
            expQ.push_back(modelOutput(((edgesSinceReset - 1) / int'(REFRESH_DIV)) % 4,
                                       prevMin, prevSec, prevBlank, blinkOff));
         end
      end
      prevMin   = m;
      prevSec   = s;
      prevBlank = b;
      prevDone  = d;
      doneRun   = nextRun;
   endtask

   task automatic checkOutput(input logic [15:0] expected);
      checks++;
      if ({an, dec_cat} !== expected) begin
         failures++;
         $display("[TB] FAIL display cycle %0d: an/dec_cat got %h/%h, want %h/%h",
                  cycleNum, an, dec_cat, expected[15:8], expected[7:0]);
      end
      checks++;
      if ($countones(~an) > 1 || an[7:4] !== 4'hF) begin
         failures++;
         $display("[TB] FAIL anode one-hot cycle %0d: an got %h, want at most one low in [3:0]",
                  cycleNum, an);
      end
   endtask

   // Monitor: one prediction is due after every edge once reset has been seen.
   initial begin
      logic [15:0] expected;
      forever begin
         @(posedge clock);
         #1;
         cycleNum++;
         if (expQ.size() > 0) begin
            expected = expQ.pop_front();
            checkOutput(expected);
         end
      end
   end

   initial begin
      logic [6:0] m;
      logic [6:0] s;
      logic       b;
      logic       d;
      logic       r;

      $display("[TB] display_scan scoreboard bench, REFRESH_DIV=%0d", REFRESH_DIV);

      repeat (3) applyStimulus(1'b1, 7'd12, 7'd34, 1'b0, 1'b0);
      repeat (20) applyStimulus(1'b0, 7'd12, 7'd34, 1'b0, 1'b0);

      repeat (16) applyStimulus(1'b0, 7'd0, 7'd99, 1'b0, 1'b0);

      repeat (16) applyStimulus(1'b0, 7'd100, 7'd7, 1'b0, 1'b0);

      repeat (6) applyStimulus(1'b0, 7'd45, 7'd23, 1'b0, 1'b0);
      repeat (5) applyStimulus(1'b0, 7'd45, 7'd23, 1'b1, 1'b0);
      repeat (10) applyStimulus(1'b0, 7'd45, 7'd23, 1'b0, 1'b0);

      repeat (40) applyStimulus(1'b0, 7'd3, 7'd59, 1'b0, 1'b1);
      repeat (10) applyStimulus(1'b0, 7'd3, 7'd59, 1'b0, 1'b0);

      repeat (14) applyStimulus(1'b0, 7'd58, 7'd16, 1'b0, 1'b0);
      applyStimulus(1'b1, 7'd58, 7'd16, 1'b0, 1'b0);
      repeat (12) applyStimulus(1'b0, 7'd58, 7'd16, 1'b0, 1'b0);

      m = 7'd10;
      s = 7'd0;
      b = 1'b0;
      d = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) m = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 3) == 0) s = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 15) == 0) b = ~b;
         if ($urandom_range(0, 19) == 0) d = ~d;
         r = ($urandom_range(0, 99) == 0);
         applyStimulus(r, m, s, b, d);
      end

      repeat (2) applyStimulus(1'b0, m, s, 1'b0, 1'b0);
      @(posedge clock);
      #3;
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard drain: %0d predictions left, want 0", expQ.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed 7-segment driver downstream of the countdown timer. Takes the remaining minutes and seconds as binary values, splits each into tens and units, and scans four digits of the board's eight-digit display. It drives the active-low anode (`an`) and segment (`dec_cat`) buses directly. Optionally blinks the display when the timer reports `done`.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit. Legal range is ≥ 2.
- `BLINK_DIV`, default 50000000: clock cycles per blink half-period. Legal range is ≥ 2. Used only with `DISPLAY_BLINK_EN`.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `min_left`  in  7  remaining minutes, binary.
- `sec_left`  in  7  remaining seconds, binary.
- `blank`  in  1  when high, all digits are off.
- `done`  in  1  timer-finished flag. Used only with `DISPLAY_BLINK_EN`.
- `an`  out  8  anode enables, active-low, one-hot-low while scanning.
- `dec_cat`  out  8  segments, active-low. Bit 7..1 = a..g, bit 0 = dp.

## Operation
- Inputs `min_left`, `sec_left`, `blank` and `done` are registered every cycle.
- Each field is split into tens and units:
  - tens = value / 10, units = value % 10.
  - A field value > 99 is out of range. Both of its digits then show dash 8'b11111101.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - At the terminal count, the 2-bit digit index advances. It wraps 3 → 0.
- Digit map:
  - index 0 = sec units, `an`=8'b11111110.
  - index 1 = sec tens, `an`=8'b11111101.
  - index 2 = min units, `an`=8'b11111011.
  - index 3 = min tens, `an`=8'b11110111.
  - `an[7:4]` are always 1.
- Segment codes, 0..9: 03, 9F, 25, 0D, 99, 49, 41, 1F, 01, 09 (hex).
- Decimal point: `dec_cat[0]`=0 only on index 2, as the min:sec separator. It is forced to 1 when the field is out of range.
- Leading zeros are displayed; there is no zero suppression.
- Blanking:
  - `blank`=1 sets `an`=8'hFF and `dec_cat`=8'hFF.
  - The counters keep running during blanking, so the scan phase is undisturbed.
- Priority: reset > blank > blink-off phase > normal scan.

## Timing
- Reset values:
  - `an`=8'hFF, `dec_cat`=8'hFF.
  - Refresh counter = 0, digit index = 0, blink counter = 0, blink phase = on.
- First cycle after reset is released: outputs still 8'hFF.
- Second cycle after reset is released: digit 0 is driven.
- Outputs are registered. They reflect the registered digit index and registered inputs, which gives 2 cycles from an input change to its visibility on the active digit.
- The digit index changes on the cycle the refresh counter wraps. `an`/`dec_cat` follow one cycle later. Each digit is lit for exactly REFRESH_DIV cycles.
- `an` and `dec_cat` change on the same clock edge. There is never a cycle with two anodes low.
- Reset asserted mid-scan: on the next edge, all state and outputs return to their reset values, regardless of the other inputs.
- Input changes mid-digit take effect within the current digit slot. There is no tearing protection.

## Configuration
- `DISPLAY_BLINK_EN` defined:
  - While registered `done`=1, the blink counter counts 0..BLINK_DIV-1. At each wrap the blink phase toggles.
  - Phase off forces `an`=8'hFF.
  - On `done` going to 0, the counter clears and the phase returns to on in the same cycle.
  - The first off phase starts BLINK_DIV cycles after `done` rises.
- `DISPLAY_BLINK_EN` undefined:
  - `done` is ignored, and no blink counter or phase logic is synthesised.
  - The port remains for interface stability.

## Structure
- Shared package `display_pkg` holds:
  - The segment constants SEG_0..SEG_9, SEG_DASH and SEG_OFF.
  - The anode constant AN_OFF.
  - A 2-bit digit-index typedef.
- Sub-module `seg7_decode`:
  - Combinational.
  - Inputs: 4-bit digit and a dash flag. Output: 7 segment bits a..g.
  - Instantiated once on the muxed digit.

## Test plan
- Reset with REFRESH_DIV=4, `min_left`=12, `sec_left`=34:
  - Held: `an`=FF, `dec_cat`=FF.
  - After release: digits cycle FE/4 = 99, FD/3 = 0D, FB/2 with dp = 24, F7/1 = 9F. Each lasts 4 cycles.
- `sec_left`=99, `min_left`=0 → digits 09, 09, 02 (0 with dp), 03.
- `min_left`=100 → index 2 shows FD (dash, dp off) and index 3 shows FD. The seconds digits are unaffected.
- `blank`=1 mid-slot → `an`=FF 2 cycles later. Release `blank` → scan resumes at the same index and the counter phase it would have had.
- With `DISPLAY_BLINK_EN` and BLINK_DIV=8, `done`=1:
  - `an` alternates 8 cycles scanning / 8 cycles FF.
  - Dropping `done` restores scanning within 2 cycles.
- Reset pulse at refresh count 2 of index 3 → outputs FF next cycle, then restart at index 0 with a full 4-cycle slot.
